// File: rtl/clk_div_multi.sv
// Multi-channel integer clock divider with deferred, glitch-free ratio updates and ack pulses.
// Optional macro CLK_DIV_SYNC_EN adds i_sync to phase-align all dividing channels.
module clk_div_multi #(
  parameter int NUM_CH    = 2,
  parameter int DIV_WIDTH = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
`ifdef CLK_DIV_SYNC_EN
  input  logic                          i_sync,
`endif
  input  logic [NUM_CH-1:0]             i_clk_en,
  input  logic [NUM_CH*DIV_WIDTH-1:0]   i_div_ratio,
  output logic [NUM_CH-1:0]             o_div_clk,
  output logic [NUM_CH-1:0]             o_ratio_ack,
  output logic [NUM_CH-1:0]             o_busy,
  output logic [2*NUM_CH-1:0]           o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BYPASS = 2'd1,
    ST_DIVIDE = 2'd2
  } state_t;

  logic sync;
`ifdef CLK_DIV_SYNC_EN
  assign sync = i_sync;
`else
  assign sync = 1'b0;
`endif

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] act_q, act_d;
    logic                 out_q, out_d;
    logic                 ack_q, ack_d;
    logic [DIV_WIDTH-1:0] ratio;
    logic [DIV_WIDTH-1:0] cnt_inc;
    logic [DIV_WIDTH-1:0] half;
    logic                 ratio_div;
    logic                 wrap;
    logic                 en;

    assign ratio     = i_div_ratio[ch*DIV_WIDTH +: DIV_WIDTH];
    assign en        = i_clk_en[ch];
    assign cnt_inc   = cnt_q + DIV_WIDTH'(1);
    assign half      = act_q >> 1;
    assign ratio_div = |ratio[DIV_WIDTH-1:1];
    // Sync behaves exactly like a natural period end so pending changes land there too.
    assign wrap      = (cnt_q == act_q - DIV_WIDTH'(1)) || sync;

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        act_q   <= '0;
        out_q   <= 1'b0;
        ack_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        act_q   <= act_d;
        out_q   <= out_d;
        ack_q   <= ack_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      act_d   = act_q;
      out_d   = out_q;
      ack_d   = 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          out_d = 1'b0;
          if (en) begin
            act_d = ratio;
            ack_d = 1'b1;
            if (ratio_div) begin
              state_d = ST_DIVIDE;
              out_d   = 1'b1;
            end else begin
              state_d = ST_BYPASS;
            end
          end
        end
        ST_BYPASS: begin
          if (!en) begin
            state_d = ST_IDLE;
          end else if (ratio != act_q) begin
            act_d = ratio;
            ack_d = 1'b1;
            if (ratio_div) begin
              state_d = ST_DIVIDE;
              cnt_d   = '0;
              out_d   = 1'b1;
            end
          end
        end
        ST_DIVIDE: begin
          if (wrap) begin
            cnt_d = '0;
            out_d = 1'b1;
            // Disable takes priority over a ratio change arriving at the same wrap.
            if (!en) begin
              state_d = ST_IDLE;
              out_d   = 1'b0;
            end else if (ratio != act_q) begin
              act_d = ratio;
              ack_d = 1'b1;
              if (!ratio_div) begin
                state_d = ST_BYPASS;
                out_d   = 1'b0;
              end
            end
          end else begin
            cnt_d = cnt_inc;
            out_d = (cnt_inc < half);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          out_d   = 1'b0;
        end
      endcase
    end

    // Only the bypass path is combinational; out_q is always 0 outside DIVIDE.
    assign o_div_clk[ch]           = out_q | (CLK & (state_q == ST_BYPASS));
    assign o_ratio_ack[ch]         = ack_q;
    assign o_busy[ch]              = (state_q == ST_DIVIDE);
    assign o_dbg_state[2*ch +: 2]  = state_q;
  end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Parametrised multi-channel integer clock divider for the UART clock domain. It generates NUM_CH independently programmed divided clocks from one reference clock: UART TX, UART RX oversampling, and spare channels. Each channel has deferred, glitch-free ratio updates and a completion handshake. Ratios come straight from register-file configuration words; outputs drive clock muxes and gates in the top level.

## Interface
Parameters:
- NUM_CH, 2, number of divider channels (1..8)
- DIV_WIDTH, 8, width of each ratio field; max ratio 2^DIV_WIDTH-1

Ports:
- CLK  in  1  reference clock, all state on rising edge
- RST  in  1  asynchronous, active-low reset
- i_clk_en  in  NUM_CH  per-channel enable
- i_div_ratio  in  NUM_CH*DIV_WIDTH  channel k ratio at bits [k*DIV_WIDTH +: DIV_WIDTH]
- o_div_clk  out  NUM_CH  divided clocks
- o_ratio_ack  out  NUM_CH  one-cycle pulse when a new ratio becomes active
- o_busy  out  NUM_CH  1 while channel is in DIVIDE state

## Operation
- Per-channel state machine with three states.
  - IDLE: output 0, counter 0.
  - BYPASS: active ratio 0 or 1; output = CLK while enabled.
  - DIVIDE: active ratio N ≥ 2.
- Per-channel registers:
  - cnt (DIV_WIDTH bits)
  - act_ratio (DIV_WIDTH bits)
  - out_q
- DIVIDE duty cycle:
  - High phase H = floor(N/2) cycles; low phase = N − H.
  - Even N gives 50%. Odd N gives one extra low cycle (N=3: 1 high, 2 low).
- Each edge in DIVIDE:
  - If cnt == N−1 (wrap): cnt ← 0, out_q ← 1, then apply pending changes.
  - Otherwise: cnt ← cnt+1, out_q ← (cnt+1 < H).
- Pending changes are applied only at wrap:
  - i_div_ratio differs from act_ratio: load it and pulse o_ratio_ack. New ratio 0/1 goes to BYPASS.
  - i_clk_en low: go to IDLE with out_q ← 0.
  - A started period always completes.
- IDLE:
  - i_clk_en high with ratio ≥ 2: load ratio, go to DIVIDE on the same edge with cnt=0, out_q=1, ack pulse.
  - i_clk_en high with ratio 0/1: go to BYPASS, ack pulse.
- BYPASS:
  - Ratio change to ≥ 2 takes effect on the next edge (cnt=0, out_q=1, ack).
  - i_clk_en low goes to IDLE on the next edge.
  - Output is combinational CLK & (state==BYPASS).
- Ratio change and enable drop at the same wrap: disable wins, no ack. The ratio is reloaded on the next enable.
- o_busy = (state==DIVIDE).

## Timing
- Reset (RST low, asynchronous, immediate):
  - All channels IDLE; cnt=0, act_ratio=0.
  - o_div_clk=0, o_ratio_ack=0, o_busy=0.
- Reset asserted mid-period: output drops to 0 without waiting for the wrap. After release, a channel restarts from IDLE on the first edge with enable.
- Latency:
  - IDLE→DIVIDE: output rises on the first edge after enable is sampled high.
  - Ratio update in DIVIDE: takes effect at the next wrap, at most N_old cycles later.
- o_ratio_ack is high for exactly one cycle, following the edge that loads act_ratio.
- Divided outputs are registered (out_q) and glitch-free. Only the BYPASS path is combinational.
- Channels are fully independent; no cross-channel timing relation unless the feature below is compiled in.

## Configuration
- Macro: CLK_DIV_SYNC_EN.
- Defined:
  - Adds input i_sync (1 bit).
  - On an edge with i_sync high, every channel in DIVIDE forces cnt←0, out_q←1.
  - Pending ratio/enable changes are applied as at a wrap, phase-aligning all channels.
  - BYPASS and IDLE channels are unaffected.
- Undefined: i_sync is absent and channels free-run.

## Test plan
- Reset, then enable ch0 with ratio 4: o_div_clk[0] reads 1,1,0,0 repeating from the first edge; ack pulses once; o_busy[0]=1.
- ch0 ratio 5: 2 cycles high, 3 low. Change to 8 at cnt=1: old period finishes (3 more cycles), then 4 high/4 low; ack coincides with the first high cycle.
- Ratio 1 and ratio 0: o_div_clk equals CLK, o_busy=0. Switch to ratio 6: output is registered 3/3 from the next edge.
- Drop i_clk_en mid-high-phase with ratio 6: high and low phases complete, then output stays 0 and o_busy falls at the wrap. Simultaneous ratio change at that wrap produces no ack.
- Assert RST low mid-period on two channels: outputs and acks go 0 immediately. After release with enables held, both restart with out=1 on the first edge.
- With CLK_DIV_SYNC_EN defined, ch0 ratio 4 and ch1 ratio 6 free-running: pulse i_sync; both outputs are 1 on the next edge and rise together again 12 cycles later.
